// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared definitions for the ID/EX pipeline stage. Defines the
//               layout of the 9-bit decoded control bundle
//               {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst,
//               ALUOp[2:0]}, the all-zero NOP bundle, the ALUOp encodings,
//               the register-specifier width and a MemRead field accessor.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int CTRL_WIDTH     = 9;
    localparam int REG_ADDR_WIDTH = 5;

    // Bit positions inside the control bundle (MSB first).
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMTOREG  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_REGDST    = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef logic [CTRL_WIDTH-1:0]     ctrl_t;
    typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;

    // An all-zero bundle has no architectural side effects in EX/MEM/WB.
    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_FUNCT = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5
    } aluOp_e;

    function automatic logic ctrlMemRead(input ctrl_t ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in EX is a valid load whose destination (Rt,
//               non-zero) is read by the valid instruction in decode.
// Ports       : i_validEx    - EX slot holds a real instruction
//               i_memReadEx  - EX instruction is a load
//               i_rtEx       - load destination register
//               i_validId    - decode slot holds a real instruction
//               i_usesRtId   - decode instruction reads Rt
//               i_rsId       - decode Rs specifier
//               i_rtId       - decode Rt specifier
//               o_loadUse    - hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic     i_validEx,
    input  logic     i_memReadEx,
    input  regAddr_t i_rtEx,
    input  logic     i_validId,
    input  logic     i_usesRtId,
    input  regAddr_t i_rsId,
    input  regAddr_t i_rtId,
    output logic     o_loadUse
);

    logic w_rsMatch;
    logic w_rtMatch;
    logic w_rtNonZero;

    assign w_rsMatch   = (i_rtEx == i_rsId);
    // Rt only counts as a source for instructions that actually read it
    // (R-type, stores, branches); for addi/lw it is the destination.
    assign w_rtMatch   = i_usesRtId & (i_rtEx == i_rtId);
    // Register 0 is hard-wired to zero, so a load into it creates no hazard.
    assign w_rtNonZero = (i_rtEx != '0);

    assign o_loadUse = i_validEx & i_memReadEx & w_rtNonZero & i_validId &
                       (w_rsMatch | w_rtMatch);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               branch flush, external hold and a saturating bubble counter.
//               Update priority per edge: rst > Hold > Flush/LoadUse >
//               capture.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               *IF2ID              - decode-side control/operands/specifiers
//               Flush               - kill the instruction in decode
//               Hold                - freeze the whole stage for one cycle
//               *ID2EX              - registered copies for EX / forwarding
//               Stall               - combinational; upstream must hold
//               BubbleCount         - bubbles inserted since reset (sat.)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTRL_WIDTH-1:0] CtrlIF2ID,
    input  logic                  ValidIF2ID,
    input  logic                  UsesRtIF2ID,
    input  logic [WIDTH-1:0]      ReadData1IF2ID,
    input  logic [WIDTH-1:0]      ReadData2IF2ID,
    input  logic [WIDTH-1:0]      SignExtIF2ID,
    input  logic [WIDTH-1:0]      PCplus4IF2ID,
    input  logic [4:0]            RsIF2ID,
    input  logic [4:0]            RtIF2ID,
    input  logic [4:0]            RdIF2ID,
    input  logic                  Flush,
    input  logic                  Hold,
    output logic [CTRL_WIDTH-1:0] CtrlID2EX,
    output logic                  ValidID2EX,
    output logic [WIDTH-1:0]      ReadData1ID2EX,
    output logic [WIDTH-1:0]      ReadData2ID2EX,
    output logic [WIDTH-1:0]      SignExtID2EX,
    output logic [WIDTH-1:0]      PCplus4ID2EX,
    output logic [4:0]            RsID2EX,
    output logic [4:0]            RtID2EX,
    output logic [4:0]            RdID2EX,
    output logic                  Stall,
    output logic [15:0]           BubbleCount
);

    localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

    ctrl_t            r_ctrl;
    logic             r_valid;
    logic [WIDTH-1:0] r_readData1;
    logic [WIDTH-1:0] r_readData2;
    logic [WIDTH-1:0] r_signExt;
    logic [WIDTH-1:0] r_pcPlus4;
    regAddr_t         r_rs;
    regAddr_t         r_rt;
    regAddr_t         r_rd;
    logic [15:0]      r_bubbleCount;

    logic w_loadUse;
    logic w_bubble;

    hazard_detect u_hazard_detect (
        .i_validEx   (r_valid),
        .i_memReadEx (ctrlMemRead(r_ctrl)),
        .i_rtEx      (r_rt),
        .i_validId   (ValidIF2ID),
        .i_usesRtId  (UsesRtIF2ID),
        .i_rsId      (RsIF2ID),
        .i_rtId      (RtIF2ID),
        .o_loadUse   (w_loadUse)
    );

    // A flush already discards the decode instruction, so a coincident
    // load-use needs no upstream stall: the replacement fetch proceeds.
    assign Stall    = (w_loadUse & ~Flush) | Hold;
    assign w_bubble = Flush | w_loadUse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl        <= CTRL_NOP;
            r_valid       <= 1'b0;
            r_readData1   <= '0;
            r_readData2   <= '0;
            r_signExt     <= '0;
            r_pcPlus4     <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_bubbleCount <= '0;
        end else if (Hold) begin
            // Whole stage frozen, counter included.
        end else if (w_bubble) begin
            // Bubble clears MemRead in EX, so the load-use condition drops
            // on the next cycle and one hazard costs exactly one bubble.
            r_ctrl      <= CTRL_NOP;
            r_valid     <= 1'b0;
            r_readData1 <= '0;
            r_readData2 <= '0;
            r_signExt   <= '0;
            r_pcPlus4   <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            if (r_bubbleCount != C_COUNT_MAX) begin
                r_bubbleCount <= r_bubbleCount + 16'd1;
            end
        end else begin
            // An empty decode slot must never carry live control into EX.
            r_ctrl      <= ValidIF2ID ? CtrlIF2ID : CTRL_NOP;
            r_valid     <= ValidIF2ID;
            r_readData1 <= ReadData1IF2ID;
            r_readData2 <= ReadData2IF2ID;
            r_signExt   <= SignExtIF2ID;
            r_pcPlus4   <= PCplus4IF2ID;
            r_rs        <= RsIF2ID;
            r_rt        <= RtIF2ID;
            r_rd        <= RdIF2ID;
        end
    end

    assign CtrlID2EX      = r_ctrl;
    assign ValidID2EX     = r_valid;
    assign ReadData1ID2EX = r_readData1;
    assign ReadData2ID2EX = r_readData2;
    assign SignExtID2EX   = r_signExt;
    assign PCplus4ID2EX   = r_pcPlus4;
    assign RsID2EX        = r_rs;
    assign RtID2EX        = r_rt;
    assign RdID2EX        = r_rd;
    assign BubbleCount    = r_bubbleCount;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A table of directed
//               per-cycle records (inputs, expected Stall before the edge,
//               expected registered outputs after the edge) plus hand-written
//               reset and counter-saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int WIDTH = 32;

    localparam logic [8:0] LW   = 9'h1D0;  // RegWrite MemToReg MemRead ALUSrc, ADD
    localparam logic [8:0] ADD  = 9'h10A;  // RegWrite RegDst, FUNCT
    localparam logic [8:0] ADDI = 9'h110;  // RegWrite ALUSrc, ADD

    logic             clk;
    logic             rst;
    logic [8:0]       CtrlIF2ID;
    logic             ValidIF2ID;
    logic             UsesRtIF2ID;
    logic [WIDTH-1:0] ReadData1IF2ID;
    logic [WIDTH-1:0] ReadData2IF2ID;
    logic [WIDTH-1:0] SignExtIF2ID;
    logic [WIDTH-1:0] PCplus4IF2ID;
    logic [4:0]       RsIF2ID;
    logic [4:0]       RtIF2ID;
    logic [4:0]       RdIF2ID;
    logic             Flush;
    logic             Hold;
    logic [8:0]       CtrlID2EX;
    logic             ValidID2EX;
    logic [WIDTH-1:0] ReadData1ID2EX;
    logic [WIDTH-1:0] ReadData2ID2EX;
    logic [WIDTH-1:0] SignExtID2EX;
    logic [WIDTH-1:0] PCplus4ID2EX;
    logic [4:0]       RsID2EX;
    logic [4:0]       RtID2EX;
    logic [4:0]       RdID2EX;
    logic             Stall;
    logic [15:0]      BubbleCount;

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .CtrlIF2ID      (CtrlIF2ID),
        .ValidIF2ID     (ValidIF2ID),
        .UsesRtIF2ID    (UsesRtIF2ID),
        .ReadData1IF2ID (ReadData1IF2ID),
        .ReadData2IF2ID (ReadData2IF2ID),
        .SignExtIF2ID   (SignExtIF2ID),
        .PCplus4IF2ID   (PCplus4IF2ID),
        .RsIF2ID        (RsIF2ID),
        .RtIF2ID        (RtIF2ID),
        .RdIF2ID        (RdIF2ID),
        .Flush          (Flush),
        .Hold           (Hold),
        .CtrlID2EX      (CtrlID2EX),
        .ValidID2EX     (ValidID2EX),
        .ReadData1ID2EX (ReadData1ID2EX),
        .ReadData2ID2EX (ReadData2ID2EX),
        .SignExtID2EX   (SignExtID2EX),
        .PCplus4ID2EX   (PCplus4ID2EX),
        .RsID2EX        (RsID2EX),
        .RtID2EX        (RtID2EX),
        .RdID2EX        (RdID2EX),
        .Stall          (Stall),
        .BubbleCount    (BubbleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand fields derive from one tag d: RD1=d, RD2=3d, SE=2d, PC4=4d,
    // so an all-zero bubble corresponds to tag 0.
    typedef struct {
        logic [8:0]  ctrl;
        logic        valid;
        logic        usesRt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        flush;
        logic        hold;
        logic        expStall;
        logic        expValid;
        logic [8:0]  expCtrl;
        logic [4:0]  expRs;
        logic [4:0]  expRt;
        logic [4:0]  expRd;
        logic [31:0] expData;
        logic [15:0] expCount;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    int nChecks = 0;
    int nPass   = 0;

    function automatic vec_t mk(
        input logic [8:0] ctrl, input logic valid, input logic usesRt,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] data, input logic flush, input logic hold,
        input logic expStall, input logic expValid, input logic [8:0] expCtrl,
        input logic [4:0] expRs, input logic [4:0] expRt, input logic [4:0] expRd,
        input logic [31:0] expData, input logic [15:0] expCount);
        vec_t v;
        v.ctrl = ctrl; v.valid = valid; v.usesRt = usesRt;
        v.rs = rs; v.rt = rt; v.rd = rd; v.data = data;
        v.flush = flush; v.hold = hold; v.expStall = expStall;
        v.expValid = expValid; v.expCtrl = expCtrl; v.expRs = expRs;
        v.expRt = expRt; v.expRd = expRd; v.expData = expData;
        v.expCount = expCount;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [8:0] ctrl, input logic valid, input logic usesRt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] data, input logic flush, input logic hold);
        CtrlIF2ID      = ctrl;
        ValidIF2ID     = valid;
        UsesRtIF2ID    = usesRt;
        RsIF2ID        = rs;
        RtIF2ID        = rt;
        RdIF2ID        = rd;
        ReadData1IF2ID = data;
        ReadData2IF2ID = data * 32'd3;
        SignExtIF2ID   = data * 32'd2;
        PCplus4IF2ID   = data * 32'd4;
        Flush          = flush;
        Hold           = hold;
    endtask

    task automatic chkOutputs(input string tag, input logic valid, input logic [8:0] ctrl,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] data, input logic [15:0] count);
        chk({tag, ".valid"}, 32'(ValidID2EX), 32'(valid));
        chk({tag, ".ctrl"},  32'(CtrlID2EX),  32'(ctrl));
        chk({tag, ".rs"},    32'(RsID2EX),    32'(rs));
        chk({tag, ".rt"},    32'(RtID2EX),    32'(rt));
        chk({tag, ".rd"},    32'(RdID2EX),    32'(rd));
        chk({tag, ".rd1"},   ReadData1ID2EX,  data);
        chk({tag, ".rd2"},   ReadData2ID2EX,  data * 32'd3);
        chk({tag, ".se"},    SignExtID2EX,    data * 32'd2);
        chk({tag, ".pc4"},   PCplus4ID2EX,    data * 32'd4);
        chk({tag, ".count"}, 32'(BubbleCount), 32'(count));
    endtask

    initial begin
        // Row layout: inputs (ctrl,valid,usesRt,rs,rt,rd,data,flush,hold) |
        // expected (stall, valid, ctrl, rs, rt, rd, data, count)
        vec[0]  = mk(LW,  1,0, 1,8,0,  100, 0,0,  0, 1,LW,  1,8,0,  100, 1'd0);
        vec[1]  = mk(ADD, 1,1, 8,9,10, 200, 0,0,  1, 0,9'h0,0,0,0,  0,   16'd1);
        vec[2]  = mk(ADD, 1,1, 8,9,10, 200, 0,0,  0, 1,ADD, 8,9,10, 200, 16'd1);
        vec[3]  = mk(LW,  1,0, 2,0,0,  300, 0,0,  0, 1,LW,  2,0,0,  300, 16'd1);
        vec[4]  = mk(ADD, 1,1, 0,5,6,  400, 0,0,  0, 1,ADD, 0,5,6,  400, 16'd1);
        vec[5]  = mk(LW,  1,0, 3,8,0,  500, 0,0,  0, 1,LW,  3,8,0,  500, 16'd1);
        vec[6]  = mk(ADDI,1,0, 4,8,0,  600, 0,0,  0, 1,ADDI,4,8,0,  600, 16'd1);
        vec[7]  = mk(LW,  1,0, 1,7,0,  700, 0,0,  0, 1,LW,  1,7,0,  700, 16'd1);
        vec[8]  = mk(ADD, 1,1, 2,7,11, 800, 0,0,  1, 0,9'h0,0,0,0,  0,   16'd2);
        vec[9]  = mk(ADD, 1,1, 2,7,11, 800, 0,0,  0, 1,ADD, 2,7,11, 800, 16'd2);
        vec[10] = mk(LW,  1,0, 1,6,0,  900, 0,0,  0, 1,LW,  1,6,0,  900, 16'd2);
        vec[11] = mk(ADD, 1,1, 6,2,12, 1000,1,0,  0, 0,9'h0,0,0,0,  0,   16'd3);
        vec[12] = mk(LW,  1,0, 1,3,0,  1100,0,0,  0, 1,LW,  1,3,0,  1100,16'd3);
        vec[13] = mk(ADD, 0,1, 3,4,13, 1200,0,0,  0, 0,9'h0,3,4,13, 1200,16'd3);
        vec[14] = mk(LW,  1,0, 1,3,0,  1300,0,0,  0, 1,LW,  1,3,0,  1300,16'd3);
        vec[15] = mk(ADD, 1,1, 3,4,14, 1400,0,1,  1, 1,LW,  1,3,0,  1300,16'd3);
        vec[16] = mk(ADDI,1,0, 9,9,9,  1500,0,1,  1, 1,LW,  1,3,0,  1300,16'd3);
        vec[17] = mk(ADD, 1,1, 3,3,3,  1600,1,1,  1, 1,LW,  1,3,0,  1300,16'd3);
        vec[18] = mk(ADDI,1,0, 5,3,0,  1700,0,0,  0, 1,ADDI,5,3,0,  1700,16'd3);
        vec[19] = mk(ADD, 1,1, 1,2,3,  1800,1,0,  0, 0,9'h0,0,0,0,  0,   16'd4);
        vec[20] = mk(ADD, 1,1, 1,2,3,  1900,0,0,  0, 1,ADD, 1,2,3,  1900,16'd4);

        // Reset for two cycles while Hold and Flush are also asserted.
        drive(ADD, 1, 1, 1, 2, 3, 50, 1, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chkOutputs("reset", 0, 9'h0, 0, 0, 0, 0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(9'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset.stall", 32'(Stall), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vec[i].ctrl, vec[i].valid, vec[i].usesRt, vec[i].rs, vec[i].rt,
                  vec[i].rd, vec[i].data, vec[i].flush, vec[i].hold);
            #1;
            chk($sformatf("v%0d.stall", i), 32'(Stall), 32'(vec[i].expStall));
            @(posedge clk);
            #1;
            chkOutputs($sformatf("v%0d", i), vec[i].expValid, vec[i].expCtrl,
                       vec[i].expRs, vec[i].expRt, vec[i].expRd,
                       vec[i].expData, vec[i].expCount);
        end

        // Reset arriving while a load-use stall is pending.
        @(negedge clk);
        drive(LW, 1, 0, 1, 8, 0, 2000, 0, 0);
        @(negedge clk);
        drive(ADD, 1, 1, 8, 9, 10, 2100, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst.preStall", 32'(Stall), 32'd1);
        @(posedge clk);
        #1;
        chkOutputs("midrst.r1", 0, 9'h0, 0, 0, 0, 0, 16'd0);
        @(negedge clk);
        drive(ADD, 1, 1, 8, 9, 10, 2100, 1, 1);
        @(posedge clk);
        #1;
        chkOutputs("midrst.r2", 0, 9'h0, 0, 0, 0, 0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(ADD, 1, 1, 8, 9, 10, 2100, 0, 0);
        #1;
        chk("midrst.postStall", 32'(Stall), 32'd0);
        @(posedge clk);
        #1;
        chkOutputs("midrst.cap", 1, ADD, 8, 9, 10, 2100, 16'd0);

        // Counter saturation driven by back-to-back flushes from zero.
        @(negedge clk);
        drive(ADD, 1, 1, 1, 2, 3, 7, 1, 0);
        for (int n = 0; n < 65534; n++) @(posedge clk);
        #1;
        chk("sat.fffe", 32'(BubbleCount), 32'h0000_FFFE);
        @(posedge clk);
        #1;
        chk("sat.ffff", 32'(BubbleCount), 32'h0000_FFFF);
        @(posedge clk);
        #1;
        chk("sat.hold", 32'(BubbleCount), 32'h0000_FFFF);
        chk("sat.valid", 32'(ValidID2EX), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
